// File: rtl/radio_rx_burst_scheduler.sv
// Per-channel RX burst scheduler: queues stream commands written over the settings
// bus and gates front-end samples into packets framed with tlast/eob.
module radio_rx_burst_scheduler #(
  parameter logic [7:0] SR_CMD_TIME_HI  = 8'd133,
  parameter logic [7:0] SR_CMD_TIME_LO  = 8'd134,
  parameter logic [7:0] SR_CMD_CTRL     = 8'd135,
  parameter logic [7:0] SR_RX_MAXLEN    = 8'd136,
  parameter int         CMD_FIFO_AWIDTH = 3,
  parameter int         CNT_WIDTH       = 28
) (
  input  logic                       ce_clk,
  input  logic                       ce_rst,
  input  logic                       clear,
  input  logic                       set_stb,
  input  logic [7:0]                 set_addr,
  input  logic [31:0]                set_data,
  input  logic [63:0]                vita_time,
  input  logic [31:0]                rx,
  input  logic                       rx_stb,
  output logic [31:0]                out_tdata,
  output logic [63:0]                out_ttime,
  output logic                       out_teob,
  output logic                       out_tlast,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic                       running,
  output logic [CMD_FIFO_AWIDTH:0]   fifo_count,
  output logic                       err_late,
  output logic                       err_overrun,
  output logic                       err_broken_chain,
  output logic                       err_cmd_overflow
);

  localparam int DEPTH   = 1 << CMD_FIFO_AWIDTH;
  localparam int ENTRY_W = 3 + CNT_WIDTH + 64;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TIME = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_LATE      = 2'd3;

  logic [1:0]               state;
  logic [ENTRY_W-1:0]       fifo_mem [DEPTH];
  logic [CMD_FIFO_AWIDTH:0] wr_ptr, rd_ptr;
  logic [31:0]              time_hi, time_lo;
  logic [15:0]              maxlen, pkt_cnt, maxlen_eff;
  logic [CNT_WIDTH-1:0]     samp_cnt;
  logic [63:0]              cmd_time;
  logic                     cmd_chain, cmd_cont, stop_pend;

  logic [ENTRY_W-1:0]   head;
  logic                 h_chain, h_timed, h_cont;
  logic [CNT_WIDTH-1:0] h_nsamps;
  logic [63:0]          h_time;
  logic ctrl_wr, stop_wr, push_req, push, pop, idle_pop, chain_pop, flush;
  logic fifo_empty, fifo_full, accept_due, overrun, accept, eob, tlast;

  assign head     = fifo_mem[rd_ptr[CMD_FIFO_AWIDTH-1:0]];
  assign h_chain  = head[ENTRY_W-1];
  assign h_timed  = head[ENTRY_W-2];
  assign h_cont   = head[ENTRY_W-3];
  assign h_nsamps = head[64 +: CNT_WIDTH];
  assign h_time   = head[63:0];

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (CMD_FIFO_AWIDTH+1)'(DEPTH));
  assign running    = (state == ST_RUN);
  assign maxlen_eff = (maxlen == 16'd0) ? 16'd1 : maxlen;

  // Zero-length non-continuous commands carry no work and are dropped silently
  assign ctrl_wr  = set_stb && (set_addr == SR_CMD_CTRL);
  assign stop_wr  = ctrl_wr && set_data[29];
  assign push_req = ctrl_wr && !set_data[29] && (set_data[28] || (set_data[CNT_WIDTH-1:0] != '0));
  assign flush    = stop_wr || overrun || (state == ST_LATE);
  assign push     = push_req && !fifo_full && !flush;

  // A stop in WAIT_TIME abandons the command before its first sample
  assign accept_due = rx_stb && ((state == ST_RUN) ||
                      ((state == ST_WAIT_TIME) && (vita_time >= cmd_time) && !stop_wr));
  assign overrun    = accept_due && out_tvalid && !out_tready;
  assign accept     = accept_due && !overrun;
  assign eob        = stop_pend || (!cmd_cont && (samp_cnt == CNT_WIDTH'(1)));
  assign tlast      = eob || (pkt_cnt == maxlen_eff);

  assign idle_pop  = (state == ST_IDLE) && !fifo_empty && !stop_wr;
  assign chain_pop = accept && eob && !stop_pend && cmd_chain && !fifo_empty && !stop_wr;
  assign pop       = idle_pop || chain_pop;

  always_ff @(posedge ce_clk) begin
    if (push)
      fifo_mem[wr_ptr[CMD_FIFO_AWIDTH-1:0]] <= {set_data[31], set_data[30], set_data[28],
                                                set_data[CNT_WIDTH-1:0], time_hi, time_lo};
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst)
      maxlen <= 16'd1000;
    else if (set_stb && (set_addr == SR_RX_MAXLEN))
      maxlen <= set_data[15:0];
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state <= ST_IDLE;  wr_ptr <= '0;  rd_ptr <= '0;
      time_hi <= '0;  time_lo <= '0;  cmd_time <= '0;
      cmd_chain <= 1'b0;  cmd_cont <= 1'b0;  stop_pend <= 1'b0;
      samp_cnt <= '0;  pkt_cnt <= 16'd1;
      out_tdata <= '0;  out_ttime <= '0;
      out_tvalid <= 1'b0;  out_tlast <= 1'b0;  out_teob <= 1'b0;
      err_late <= 1'b0;  err_overrun <= 1'b0;
      err_broken_chain <= 1'b0;  err_cmd_overflow <= 1'b0;
    end else if (clear) begin
      state <= ST_IDLE;  wr_ptr <= '0;  rd_ptr <= '0;
      time_hi <= '0;  time_lo <= '0;  cmd_time <= '0;
      cmd_chain <= 1'b0;  cmd_cont <= 1'b0;  stop_pend <= 1'b0;
      samp_cnt <= '0;  pkt_cnt <= 16'd1;
      out_tdata <= '0;  out_ttime <= '0;
      out_tvalid <= 1'b0;  out_tlast <= 1'b0;  out_teob <= 1'b0;
      err_late <= 1'b0;  err_overrun <= 1'b0;
      err_broken_chain <= 1'b0;  err_cmd_overflow <= 1'b0;
    end else begin
      err_late         <= 1'b0;
      err_overrun      <= 1'b0;
      err_broken_chain <= 1'b0;
      err_cmd_overflow <= push_req && fifo_full;

      if (set_stb && (set_addr == SR_CMD_TIME_HI)) time_hi <= set_data;
      if (set_stb && (set_addr == SR_CMD_TIME_LO)) time_lo <= set_data;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;

      if (accept) begin
        out_tdata  <= rx;
        out_ttime  <= vita_time;
        out_tvalid <= 1'b1;
        out_tlast  <= tlast;
        out_teob   <= eob;
        pkt_cnt    <= tlast ? 16'd1 : pkt_cnt + 16'd1;
        samp_cnt   <= samp_cnt - CNT_WIDTH'(1);
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (idle_pop) begin
            samp_cnt  <= h_nsamps;
            cmd_chain <= h_chain;
            cmd_cont  <= h_cont;
            cmd_time  <= h_time;
            pkt_cnt   <= 16'd1;
            if (h_timed && (vita_time > h_time)) state <= ST_LATE;
            else if (h_timed)                     state <= ST_WAIT_TIME;
            else                                  state <= ST_RUN;
          end
        end
        ST_LATE: begin
          err_late <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          if (overrun) begin
            err_overrun <= 1'b1;
            stop_pend   <= 1'b0;
            state       <= ST_IDLE;
          end else if (accept && eob) begin
            stop_pend <= 1'b0;
            // Chained follow-on starts immediately; its timed flag is ignored
            if (chain_pop) begin
              samp_cnt  <= h_nsamps;
              cmd_chain <= h_chain;
              cmd_cont  <= h_cont;
              cmd_time  <= h_time;
              state     <= ST_RUN;
            end else begin
              err_broken_chain <= cmd_chain && !stop_pend && !stop_wr;
              state            <= ST_IDLE;
            end
          end else if (accept) begin
            state <= ST_RUN;
            if (stop_wr) stop_pend <= 1'b1;
          end else if (stop_wr) begin
            if (state == ST_WAIT_TIME) state <= ST_IDLE;
            else                       stop_pend <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radio_rx_burst_scheduler.sv
// Directed bench for radio_rx_burst_scheduler: framing, timing, chaining, stop and error paths.
module tb_radio_rx_burst_scheduler;

  localparam logic [7:0] A_HI = 8'd133, A_LO = 8'd134, A_CTRL = 8'd135, A_MAXLEN = 8'd136;
  localparam int CAP = 1200;

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b1;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [63:0] vita_time = '0;
  logic [31:0] rx = '0;
  logic        rx_stb = 1'b0;
  logic        out_tready = 1'b1;
  logic [31:0] out_tdata;
  logic [63:0] out_ttime;
  logic        out_teob, out_tlast, out_tvalid, running;
  logic [3:0]  fifo_count;
  logic        err_late, err_overrun, err_broken_chain, err_cmd_overflow;

  radio_rx_burst_scheduler dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .vita_time(vita_time), .rx(rx), .rx_stb(rx_stb),
    .out_tdata(out_tdata), .out_ttime(out_ttime), .out_teob(out_teob),
    .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .running(running), .fifo_count(fifo_count),
    .err_late(err_late), .err_overrun(err_overrun),
    .err_broken_chain(err_broken_chain), .err_cmd_overflow(err_cmd_overflow)
  );

  always #5 ce_clk = ~ce_clk;

  int checks = 0;
  int errors = 0;
  int nbeats, n_late, n_ovr, n_broken;
  logic        cap_last [CAP];
  logic        cap_eob  [CAP];
  logic [31:0] cap_data [CAP];
  logic [63:0] cap_time [CAP];
  logic [31:0] rx_seq = 32'h1000;

  task automatic tick();
    @(posedge ce_clk);
    #1;
    vita_time = vita_time + 64'd1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic cap_clear();
    nbeats = 0; n_late = 0; n_ovr = 0; n_broken = 0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rx_stb = 1'b1; rx = rx_seq; rx_seq = rx_seq + 32'd1;
      tick();
      if (out_tvalid && out_tready && nbeats < CAP) begin
        cap_last[nbeats] = out_tlast; cap_eob[nbeats] = out_teob;
        cap_data[nbeats] = out_tdata; cap_time[nbeats] = out_ttime;
        nbeats++;
      end
      if (err_late) n_late++;
      if (err_overrun) n_ovr++;
      if (err_broken_chain) n_broken++;
    end
    rx_stb = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_tvalid, out_tlast, out_teob, running} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {out_tvalid, out_tlast, out_teob, running});
    end
    checks++;
    if (out_tdata !== 32'd0 || out_ttime !== 64'd0) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0/0", out_tdata, out_ttime);
    end
    checks++;
    if (fifo_count !== 4'd0 || {err_late, err_overrun, err_broken_chain, err_cmd_overflow} !== 4'b0) begin
      errors++; $display("FAIL reset_fifo_err: got count %0d errs %b expected 0 0000", fifo_count,
                         {err_late, err_overrun, err_broken_chain, err_cmd_overflow});
    end
    ce_rst = 1'b0;
    tick();
  endtask

  task automatic test_untimed_burst();
    logic [4:0] exp_last = 5'b11010;
    wr(A_MAXLEN, 32'd2);
    wr(A_CTRL, 32'd5);
    cap_clear();
    run_cycles(12);
    checks++;
    if (nbeats !== 5) begin errors++; $display("FAIL untimed_beats: got %0d expected 5", nbeats); end
    for (int i = 0; i < 5 && i < nbeats; i++) begin
      checks++;
      if (cap_last[i] !== exp_last[i] || cap_eob[i] !== (i == 4)) begin
        errors++; $display("FAIL untimed_beat%0d: got last %b eob %b expected last %b eob %b",
                           i + 1, cap_last[i], cap_eob[i], exp_last[i], (i == 4));
      end
    end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL untimed_running: got %b expected 0", running); end
  endtask

  task automatic test_timed();
    vita_time = 64'd890;
    wr(A_HI, 32'd0);
    wr(A_LO, 32'd1000);
    wr(A_CTRL, 32'h4000_0001);
    cap_clear();
    run_cycles(130);
    checks++;
    if (nbeats !== 1) begin errors++; $display("FAIL timed_beats: got %0d expected 1", nbeats); end
    checks++;
    if (cap_time[0] !== 64'd1000) begin
      errors++; $display("FAIL timed_ttime: got %0d expected 1000", cap_time[0]);
    end
  endtask

  task automatic test_late();
    vita_time = 64'd1001;
    wr(A_LO, 32'd1000);
    wr(A_CTRL, 32'h4000_0003);
    cap_clear();
    run_cycles(8);
    checks++;
    if (n_late !== 1) begin errors++; $display("FAIL late_pulse: got %0d expected 1", n_late); end
    checks++;
    if (nbeats !== 0 || fifo_count !== 4'd0) begin
      errors++; $display("FAIL late_nobeats: got beats %0d count %0d expected 0 0", nbeats, fifo_count);
    end
  endtask

  task automatic test_chain();
    logic [4:0] exp_eob = 5'b10100;
    wr(A_MAXLEN, 32'd100);
    wr(A_CTRL, 32'h8000_0003);
    wr(A_CTRL, 32'h0000_0002);
    cap_clear();
    run_cycles(10);
    checks++;
    if (nbeats !== 5) begin errors++; $display("FAIL chain_beats: got %0d expected 5", nbeats); end
    for (int i = 0; i < 5 && i < nbeats; i++) begin
      checks++;
      if (cap_eob[i] !== exp_eob[i] || cap_last[i] !== exp_eob[i] || cap_data[i] !== cap_data[0] + 32'(i)) begin
        errors++; $display("FAIL chain_beat%0d: got eob %b last %b data %h expected eob %b last %b data %h",
                           i + 1, cap_eob[i], cap_last[i], cap_data[i], exp_eob[i], exp_eob[i], cap_data[0] + 32'(i));
      end
    end
    checks++;
    if (n_broken !== 0) begin errors++; $display("FAIL chain_no_break: got %0d expected 0", n_broken); end
  endtask

  task automatic test_broken_chain();
    wr(A_CTRL, 32'h8000_0003);
    cap_clear();
    run_cycles(8);
    checks++;
    if (nbeats !== 3) begin errors++; $display("FAIL broken_beats: got %0d expected 3", nbeats); end
    checks++;
    if (n_broken !== 1) begin errors++; $display("FAIL broken_pulse: got %0d expected 1", n_broken); end
  endtask

  task automatic test_continuous_stop();
    wr(A_MAXLEN, 32'd4);
    wr(A_CTRL, 32'h1000_0000);
    cap_clear();
    run_cycles(11);
    wr(A_CTRL, 32'h2000_0000);
    run_cycles(4);
    checks++;
    if (nbeats !== 11) begin errors++; $display("FAIL cont_beats: got %0d expected 11", nbeats); end
    for (int i = 0; i < 11 && i < nbeats; i++) begin
      checks++;
      if (cap_last[i] !== (i == 3 || i == 7 || i == 10) || cap_eob[i] !== (i == 10)) begin
        errors++; $display("FAIL cont_beat%0d: got last %b eob %b expected last %b eob %b", i + 1,
                           cap_last[i], cap_eob[i], (i == 3 || i == 7 || i == 10), (i == 10));
      end
    end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL cont_idle: got running %b expected 0", running); end
  endtask

  task automatic test_maxlen_zero();
    wr(A_MAXLEN, 32'd0);
    wr(A_CTRL, 32'd3);
    cap_clear();
    run_cycles(6);
    checks++;
    if (nbeats !== 3) begin errors++; $display("FAIL ml0_beats: got %0d expected 3", nbeats); end
    for (int i = 0; i < 3 && i < nbeats; i++) begin
      checks++;
      if (cap_last[i] !== 1'b1 || cap_eob[i] !== (i == 2)) begin
        errors++; $display("FAIL ml0_beat%0d: got last %b eob %b expected last 1 eob %b",
                           i + 1, cap_last[i], cap_eob[i], (i == 2));
      end
    end
  endtask

  task automatic test_overrun();
    wr(A_CTRL, 32'd5);
    wr(A_CTRL, 32'd5);
    out_tready = 1'b0;
    rx_stb = 1'b1; rx = 32'hA1;
    tick();
    rx = 32'hA2;
    tick();
    checks++;
    if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b expected 1", err_overrun); end
    rx_stb = 1'b0;
    tick();
    checks++;
    if (err_overrun !== 1'b0) begin errors++; $display("FAIL overrun_single: got %b expected 0", err_overrun); end
    checks++;
    if (out_tvalid !== 1'b1 || out_tdata !== 32'hA1) begin
      errors++; $display("FAIL overrun_hold: got valid %b data %h expected 1 a1", out_tvalid, out_tdata);
    end
    checks++;
    if (fifo_count !== 4'd0 || running !== 1'b0) begin
      errors++; $display("FAIL overrun_flush: got count %0d running %b expected 0 0", fifo_count, running);
    end
    out_tready = 1'b1;
    tick();
    checks++;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL overrun_drain: got %b expected 0", out_tvalid); end
  endtask

  task automatic test_cmd_overflow();
    int n_ovf = 0;
    wr(A_HI, 32'd1);
    wr(A_CTRL, 32'h4000_0001);
    tick();
    for (int i = 0; i < 9; i++) begin
      wr(A_CTRL, 32'd1);
      if (err_cmd_overflow) n_ovf++;
    end
    checks++;
    if (n_ovf !== 1) begin errors++; $display("FAIL overflow_pulse: got %0d expected 1", n_ovf); end
    checks++;
    if (fifo_count !== 4'd8) begin errors++; $display("FAIL overflow_count: got %0d expected 8", fifo_count); end
    wr(A_CTRL, 32'h2000_0000);
    tick();
    checks++;
    if (fifo_count !== 4'd0 || running !== 1'b0) begin
      errors++; $display("FAIL overflow_stop: got count %0d running %b expected 0 0", fifo_count, running);
    end
  endtask

  task automatic test_async_reset();
    int nlast = 0;
    wr(A_MAXLEN, 32'd3);
    wr(A_CTRL, 32'd20);
    wr(A_CTRL, 32'd5);
    cap_clear();
    run_cycles(5);
    #3 ce_rst = 1'b1;
    #1;
    checks++;
    if ({out_tvalid, out_tlast, out_teob, running} !== 4'b0 || out_tdata !== 32'd0 || out_ttime !== 64'd0) begin
      errors++; $display("FAIL async_rst_out: got %b data %h expected 0000 0",
                         {out_tvalid, out_tlast, out_teob, running}, out_tdata);
    end
    checks++;
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL async_rst_fifo: got %0d expected 0", fifo_count); end
    #2 ce_rst = 1'b0;
    tick();
    wr(A_CTRL, 32'd1001);
    cap_clear();
    run_cycles(1006);
    checks++;
    if (nbeats !== 1001) begin errors++; $display("FAIL rst_ml_beats: got %0d expected 1001", nbeats); end
    for (int i = 0; i < nbeats; i++) if (cap_last[i]) nlast++;
    checks++;
    if (nlast !== 2 || cap_last[999] !== 1'b1 || cap_eob[1000] !== 1'b1) begin
      errors++; $display("FAIL rst_ml_default: got %0d tlasts last999 %b eob1000 %b expected 2 1 1",
                         nlast, cap_last[999], cap_eob[1000]);
    end
  endtask

  initial begin
    test_reset();
    test_untimed_burst();
    test_timed();
    test_late();
    test_chain();
    test_broken_chain();
    test_continuous_stop();
    test_maxlen_zero();
    test_overrun();
    test_cmd_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
